// File: rtl/muldiv_pkg.sv
// Shared encodings for the multiply/divide sequencer: op codes, FSM states, default width.
package muldiv_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic [2:0] OP_MUL   = 3'd0;
  localparam logic [2:0] OP_UMULL = 3'd1;
  localparam logic [2:0] OP_SMULL = 3'd2;
  localparam logic [2:0] OP_UDIV  = 3'd3;
  localparam logic [2:0] OP_SDIV  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PREP  = 3'd1,
    S_ITER  = 3'd2,
    S_FIXUP = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  function automatic logic op_legal(input logic [2:0] op);
    return op <= OP_SDIV;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 step: right-shifting shift-add for multiply, left-shifting restoring
// shift-subtract for divide. {acc, shifter} is the double-width working register.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] shifter,
  input  logic [WIDTH-1:0] operand,
  input  logic             is_div,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] shifter_next
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem;
  logic           fits;

  always_comb begin
    sum          = {1'b0, acc} + {1'b0, operand};
    rem          = {acc, shifter[WIDTH-1]};
    fits         = rem >= {1'b0, operand};
    acc_next     = acc;
    shifter_next = shifter;
    if (is_div) begin
      // Partial remainder stays below 2*divisor, so the low WIDTH bits of the difference are exact.
      acc_next     = fits ? (rem[WIDTH-1:0] - operand) : rem[WIDTH-1:0];
      shifter_next = {shifter[WIDTH-2:0], fits};
    end else if (shifter[0]) begin
      {acc_next, shifter_next} = {sum, shifter[WIDTH-1:1]};
    end else begin
      {acc_next, shifter_next} = {1'b0, acc, shifter[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide unit. States: IDLE wait | PREP magnitudes, div-by-zero |
// ITER WIDTH steps | FIXUP sign correction, flags | DONE one-cycle result strobe.
import muldiv_pkg::*;

module muldiv_sequencer #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic [1:0]       nz_flags,
  output logic             dbz
);

  state_t             state, state_n;
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   acc, shifter, operand;
  logic [WIDTH-1:0]   acc_nx, shifter_nx, fix_lo, fix_hi;
  logic [CNT_W-1:0]   count;
  logic               sign_q, sign_r;
  logic               is_div, is_signed, div_zero, a_neg, b_neg;
  logic [2*WIDTH-1:0] prod;
  logic [1:0]         fix_nz;

  assign is_div    = (op_q == OP_UDIV) || (op_q == OP_SDIV);
  assign is_signed = (op_q == OP_SMULL) || (op_q == OP_SDIV);
  assign div_zero  = is_div && (operand == '0);
  assign a_neg     = is_signed & shifter[WIDTH-1];
  assign b_neg     = is_signed & operand[WIDTH-1];
  assign busy      = (state == S_PREP) || (state == S_ITER) || (state == S_FIXUP);
  assign done      = (state == S_DONE);

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc          (acc),
    .shifter      (shifter),
    .operand      (operand),
    .is_div       (is_div),
    .acc_next     (acc_nx),
    .shifter_next (shifter_nx)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (start) state_n = op_legal(op) ? S_PREP : S_DONE;
      S_PREP:  state_n = div_zero ? S_DONE : S_ITER;
      S_ITER:  if (count == CNT_W'(WIDTH - 1)) state_n = S_FIXUP;
      S_FIXUP: state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (flush) state_n = S_IDLE;
  end

  always_comb begin
    prod   = {acc, shifter};
    fix_lo = shifter;
    fix_hi = acc;
    case (op_q)
      OP_MUL:   fix_hi = '0;
      OP_SMULL: if (sign_q) {fix_hi, fix_lo} = -prod;
      OP_SDIV: begin
        if (sign_q) fix_lo = -shifter;
        if (sign_r) fix_hi = -acc;
      end
      default: ;
    endcase
    fix_nz[1] = (op_q == OP_MUL) ? fix_lo[WIDTH-1] : fix_hi[WIDTH-1];
    fix_nz[0] = ({fix_hi, fix_lo} == '0);
  end

  // Flush suppresses every register update, so prior results stay visible.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q      <= '0;
      acc       <= '0;
      shifter   <= '0;
      operand   <= '0;
      count     <= '0;
      sign_q    <= 1'b0;
      sign_r    <= 1'b0;
      result_lo <= '0;
      result_hi <= '0;
      nz_flags  <= '0;
      dbz       <= 1'b0;
    end else if (!flush) begin
      case (state)
        S_IDLE: if (start) begin
          op_q    <= op;
          shifter <= src_a;
          operand <= src_b;
          dbz     <= 1'b0;
          if (!op_legal(op)) begin
            result_lo <= '0;
            result_hi <= '0;
            nz_flags  <= '0;
          end
        end
        S_PREP: begin
          acc   <= '0;
          count <= '0;
          if (div_zero) begin
            result_lo <= '0;
            result_hi <= shifter;
            nz_flags  <= '0;
            dbz       <= 1'b1;
          end else begin
            shifter <= a_neg ? -shifter : shifter;
            operand <= b_neg ? -operand : operand;
            sign_q  <= a_neg ^ b_neg;
            sign_r  <= a_neg;
          end
        end
        S_ITER: begin
          acc     <= acc_nx;
          shifter <= shifter_nx;
          count   <= count + 1'b1;
        end
        S_FIXUP: begin
          result_lo <= fix_lo;
          result_hi <= fix_hi;
          nz_flags  <= fix_nz;
        end
        default: ;
      endcase
    end
  end

endmodule
